// File: rtl/bnq_pkg.sv
// Shared types and widths for the BN-quantisation sequencer and its datapath.
package bnq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, WAIT, STREAM, DRAIN, DONE} bnq_state_e;
  localparam int GAMMA_W    = 16;
  localparam int BETA_W     = 32;
  localparam int CODE_W     = 4;
  localparam int BETA_ALIGN = 9;  // X*gamma carries 14 fraction bits, beta carries 23
endpackage

// File: rtl/bn_quant_4bit.sv
// Combinational BN + 4-bit quantiser: y = sat(round((x*gamma*2^9 + beta) / 2^(Q+S))).
module bn_quant_4bit
  import bnq_pkg::*;
#(
  parameter int XW          = 22,
  parameter int Q           = 18,
  parameter int S           = 8,
  parameter int SIGNED_MODE = 1
)(
  input  logic signed [XW-1:0]      x_in,
  input  logic signed [GAMMA_W-1:0] gamma,
  input  logic signed [BETA_W-1:0]  beta,
  output logic [CODE_W-1:0]         y_out
);
  localparam int SH = Q + S;
  localparam int AW = XW + GAMMA_W + BETA_ALIGN + 2;

  logic signed [AW-1:0] acc, rnd;

  always_comb begin
    acc = ((AW'(x_in) * AW'(gamma)) <<< BETA_ALIGN) + AW'(beta);
    rnd = (acc + (AW'(1) <<< (SH - 1))) >>> SH;
    if (SIGNED_MODE != 0) begin
      if (rnd > AW'(7))        y_out = 4'h7;
      else if (rnd < -AW'(8))  y_out = 4'h8;
      else                     y_out = rnd[CODE_W-1:0];
    end else begin
      if (rnd > AW'(15))       y_out = 4'hf;
      else if (rnd < AW'(0))   y_out = 4'h0;
      else                     y_out = rnd[CODE_W-1:0];
    end
  end
endmodule

// File: rtl/bn_quant_ctrl.sv
// Layer sequencer: param fetch per channel, stream accumulators through bn_quant_4bit, pack nibbles.
// Optional macro BNQ_RELU_EN: honour cfg_relu by forcing negative codes to zero.
module bn_quant_ctrl
  import bnq_pkg::*;
#(
  parameter int XW   = 22,
  parameter int Q    = 18,
  parameter int S    = 8,
  parameter int CHW  = 10,
  parameter int PXW  = 16,
  parameter int PACK = 8
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHW-1:0]            cfg_num_ch,
  input  logic [PXW-1:0]            cfg_pix_ch,
  input  logic                      cfg_relu,
  output logic                      busy,
  output logic                      done,
  output logic                      prm_rd_en,
  output logic [CHW-1:0]            prm_rd_addr,
  input  logic signed [GAMMA_W-1:0] prm_gamma,
  input  logic signed [BETA_W-1:0]  prm_beta,
  input  logic                      acc_valid,
  output logic                      acc_ready,
  input  logic signed [XW-1:0]      acc_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*PACK-1:0]         out_data,
  output logic                      out_last
);
  localparam int NW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int OW = CODE_W * PACK;

  bnq_state_e state, state_nxt;
  logic [CHW-1:0]            num_ch_r, ch;
  logic [PXW-1:0]            pix_ch_r, pix;
  logic [NW-1:0]             nib;
  logic [OW-1:0]             pack_r, word_nxt;
  logic signed [GAMMA_W-1:0] gamma_r;
  logic signed [BETA_W-1:0]  beta_r;
  logic [CODE_W-1:0]         code_raw, code;
  logic acc_fire, out_fire, last_pix, last_ch, word_full, empty_cfg;

  assign acc_ready = (state == STREAM) && (!out_valid || out_ready);
  assign acc_fire  = acc_valid && acc_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_pix  = (pix == pix_ch_r - PXW'(1));
  assign last_ch   = (ch == num_ch_r - CHW'(1));
  assign word_full = (nib == NW'(PACK - 1));
  assign empty_cfg = (cfg_num_ch == '0) || (cfg_pix_ch == '0);
  assign prm_rd_en   = (state == LOAD);
  assign prm_rd_addr = ch;

  bn_quant_4bit #(.XW(XW), .Q(Q), .S(S), .SIGNED_MODE(1)) u_quant (
    .x_in (acc_data),
    .gamma(gamma_r),
    .beta (beta_r),
    .y_out(code_raw)
  );

`ifdef BNQ_RELU_EN
  logic relu_r;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     relu_r <= 1'b0;
    else if (state == IDLE && start) relu_r <= cfg_relu;
  end
  assign code = (relu_r && code_raw[CODE_W-1]) ? '0 : code_raw;
`else
  assign code = code_raw;
`endif

  assign word_nxt = pack_r | (OW'(code) << {nib, 2'b00});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = empty_cfg ? DONE : LOAD;
      LOAD:    state_nxt = WAIT;
      WAIT:    state_nxt = STREAM;
      STREAM:  if (acc_fire && last_pix) state_nxt = last_ch ? DRAIN : LOAD;
      DRAIN:   if (out_fire && out_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      num_ch_r  <= '0;
      pix_ch_r  <= '0;
      ch        <= '0;
      pix       <= '0;
      nib       <= '0;
      pack_r    <= '0;
      gamma_r   <= '0;
      beta_r    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      // busy falls on the same edge that raises done
      busy  <= (state_nxt != IDLE);
      done  <= (state == DONE);
      if (state == IDLE && start) begin
        num_ch_r <= cfg_num_ch;
        pix_ch_r <= cfg_pix_ch;
        ch       <= '0;
        pix      <= '0;
        nib      <= '0;
        pack_r   <= '0;
      end
      if (state == WAIT) begin
        gamma_r <= prm_gamma;
        beta_r  <= prm_beta;
      end
      if (out_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
      if (acc_fire) begin
        // acc_ready guarantees the out register is free or draining this edge
        if (word_full || last_pix) begin
          out_valid <= 1'b1;
          out_data  <= word_nxt;
          out_last  <= last_pix && last_ch;
          pack_r    <= '0;
          nib       <= '0;
        end else begin
          pack_r <= word_nxt;
          nib    <= nib + NW'(1);
        end
        if (last_pix) begin
          pix <= '0;
          if (!last_ch) ch <= ch + CHW'(1);
        end else begin
          pix <= pix + PXW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_bn_quant_ctrl.sv
// Randomised self-checking bench for bn_quant_ctrl against a real-arithmetic layer model.
module tb_bn_quant_ctrl;
  localparam int XW = 22, Q = 18, S = 8, CHW = 10, PXW = 16, PACK = 8, OW = 4 * PACK;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cfg_relu = 1'b0;
  logic acc_valid = 1'b0, out_ready = 1'b0;
  logic [CHW-1:0] cfg_num_ch = '0;
  logic [PXW-1:0] cfg_pix_ch = '0;
  logic busy, done, prm_rd_en, acc_ready, out_valid, out_last;
  logic [CHW-1:0] prm_rd_addr;
  logic signed [15:0] prm_gamma = '0;
  logic signed [31:0] prm_beta = '0;
  logic signed [XW-1:0] acc_data = '0;
  logic [OW-1:0] out_data;
  int n_tests = 0, n_fail = 0;
  int gam[16];
  int bet[16];

  always #5 clk = ~clk;

  bn_quant_ctrl #(.XW(XW), .Q(Q), .S(S), .CHW(CHW), .PXW(PXW), .PACK(PACK)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_pix_ch(cfg_pix_ch),
    .cfg_relu(cfg_relu), .busy(busy), .done(done), .prm_rd_en(prm_rd_en), .prm_rd_addr(prm_rd_addr),
    .prm_gamma(prm_gamma), .prm_beta(prm_beta), .acc_valid(acc_valid), .acc_ready(acc_ready),
    .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last)
  );

  // parameter RAM: data one cycle after the read strobe
  always @(posedge clk)
    if (prm_rd_en) begin
      prm_gamma <= 16'(gam[prm_rd_addr[3:0]]);
      prm_beta  <= 32'(bet[prm_rd_addr[3:0]]);
    end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // value = x*gamma/2^14 + beta/2^23; code = round(value * 2^23 / 2^(Q+S)) saturated to [-8,7]
  function automatic logic [3:0] ref_code(input longint x, input longint g, input longint b, input bit relu);
    real v;
    longint q;
    v = (real'(x) * real'(g) / 16384.0 + real'(b) / 8388608.0) * 8388608.0 / real'(64'd1 << (Q + S));
    q = longint'($floor(v + 0.5));
    if (q > 7) q = 7;
    if (q < -8) q = -8;
`ifdef BNQ_RELU_EN
    if (relu && q < 0) q = 0;
`endif
    return q[3:0];
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ctl"}, {busy, done, prm_rd_en, acc_ready, out_valid, out_last}, '0);
    chk({tag, "_data"}, out_data, '0);
    chk({tag, "_addr"}, prm_rd_addr, '0);
  endtask

  // mode 0: gamma=1.0 beta=0 X=1024; mode 1: random; mode 2: X=-2048 gamma=1.0
  task automatic run_layer(input int nch, input int npix, input bit relu, input int mode,
                           input bit stalls, input int abort_cyc);
    logic signed [XW-1:0] xs[$];
    logic [OW-1:0] ew[$];
    bit el[$];
    int ea[$];
    logic [OW-1:0] w, hd;
    int k, x, xi, wi, ai;
    bit held, got_done;
    for (int c = 0; c < nch; c++) begin
      gam[c] = (mode == 1) ? int'($urandom_range(8192, 24576)) : 16384;
      bet[c] = (mode == 1) ? int'($urandom_range(0, 134217728)) - 67108864 : 0;
      ea.push_back(c);
      w = '0; k = 0;
      for (int p = 0; p < npix; p++) begin
        x = (mode == 0) ? 1024 : (mode == 2) ? -2048 : int'($urandom_range(0, 200)) - 100;
        xs.push_back(XW'(x));
        w = w | (OW'(ref_code(x, gam[c], bet[c], relu)) << (4 * k));
        k++;
        if (k == PACK || p == npix - 1) begin
          ew.push_back(w);
          el.push_back(c == nch - 1 && p == npix - 1);
          w = '0; k = 0;
        end
      end
    end
    cfg_num_ch = CHW'(nch); cfg_pix_ch = PXW'(npix); cfg_relu = relu;
    xi = 0; wi = 0; ai = 0; held = 0; got_done = 0; hd = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      out_ready = !stalls || ((cyc < 20 || cyc >= 25) && ($urandom_range(0, 3) != 0));
      acc_valid = (xi < xs.size()) && (!stalls || $urandom_range(0, 4) != 0);
      acc_data = (xi < xs.size()) ? xs[xi] : '0;
      #1;
      if (abort_cyc > 0 && cyc == abort_cyc) begin
        chk("pre_abort_addr", prm_rd_addr, 1);
        chk("pre_abort_ready", acc_ready, 1);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        start = 1'b0; acc_valid = 1'b0;
        rst_n = 1'b1;
        return;
      end
      if (prm_rd_en) begin
        chk("prm_addr", prm_rd_addr, (ai < ea.size()) ? ea[ai] : 'hffff);
        ai++;
      end
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hd);
      end
      if (out_valid && !out_ready) chk("stall_acc_ready", acc_ready, 0);
      held = out_valid && !out_ready;
      hd = out_data;
      if (acc_valid && acc_ready) xi++;
      if (out_valid && out_ready) begin
        if (wi < ew.size()) begin
          chk("word", out_data, ew[wi]);
          chk("last", out_last, el[wi]);
        end else begin
          chk("extra_word", 1, 0);
        end
        wi++;
      end
      if (done) begin
        got_done = 1;
        chk("busy_at_done", busy, 0);
        break;
      end
    end
    start = 1'b0; acc_valid = 1'b0;
    chk("done_seen", got_done, 1);
    chk("word_count", wi, ew.size());
    chk("value_count", xi, xs.size());
    chk("read_count", ai, ea.size());
  endtask

  task automatic zero_layer(input int nch, input int npix);
    int dcyc;
    cfg_num_ch = CHW'(nch); cfg_pix_ch = PXW'(npix); cfg_relu = 1'b0;
    dcyc = -1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      start = (cyc == 0);
      out_ready = 1'b1;
      #1;
      chk("zero_prm_rd", prm_rd_en, 0);
      chk("zero_out_valid", out_valid, 0);
      if (cyc == 1) chk("zero_busy_c1", busy, 1);
      if (cyc == 2) chk("zero_busy_c2", busy, 0);
      if (done && dcyc < 0) dcyc = cyc;
    end
    start = 1'b0;
    chk("zero_done_cyc", dcyc, 2);
  endtask

  initial begin
    #1;
    chk_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_layer(2, 8, 0, 0, 0, 0);
    run_layer(1, 3, 0, 1, 0, 0);
    zero_layer(0, 5);
    zero_layer(3, 0);
    run_layer(2, 8, 0, 1, 0, 15);
    run_layer(2, 8, 0, 1, 0, 0);
    for (int i = 0; i < 6; i++)
      run_layer(int'($urandom_range(1, 4)), int'($urandom_range(1, 20)), 0, 1, 1, 0);
    run_layer(1, 4, 1, 2, 0, 0);
    run_layer(1, 4, 0, 2, 0, 0);
    run_layer(3, 17, 1, 1, 1, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
